mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Iterative multi-cycle sequencer for the RV64M/RV64M-W ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU + W forms).
//  Sits beside the single-cycle ALU in the execute stage; the ALU keeps the base-integer ops.
//  Accepts one op via valid/ready, runs shift-add multiply or restoring divide one bit per cycle, returns a DW-bit result.
// PARAMETERS
//  DW  64  datapath width; W ops act on the low DW/2 bits. DW must be even and >= 8.
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, asynchronous, active-high
//  flush       in   1      sync kill of any in-flight op (pipeline redirect)
//  in_valid    in   1      op request
//  in_ready    out  1      unit can accept; = (state==IDLE) & ~flush
//  in_op       in   3      M op code; encodings from alu_pkg (MUL=000 .. REMU=111)
//  in_word     in   1      1 = W form (MULW/DIVW/DIVUW/REMW/REMUW)
//  in_src1     in   DW     operand 1 (rs1)
//  in_src2     in   DW     operand 2 (rs2)
//  out_valid   out  1      result valid, held until out_ready
//  out_ready   in   1      consumer accepts result
//  out_result  out  DW     result
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_result=0, busy=0, in_ready=1, counter=0. Reset mid-op discards the op silently.
//  FSM IDLE -> CALC -> DONE -> IDLE. Accept = in_valid & in_ready at an edge (cycle T).
//   IDLE: on accept latch op/word/operands. Special case -> DONE. Else -> CALC with cnt = in_word ? DW/2 : DW.
//   CALC: one iteration per cycle; cnt decrements. At cnt==1 apply the sign fix and -> DONE.
//   DONE: out_valid=1, out_result stable. On out_ready -> IDLE. No accept in DONE; min gap between ops = 1 IDLE cycle.
//  Latency: normal op -> out_valid first high in cycle T+N+1 (N=DW or DW/2). Special case -> cycle T+1.
//  Operand prep: W ops sign-extend (signed ops) or zero-extend (unsigned ops) the low DW/2 bits.
//   Signed ops iterate on magnitudes. Result sign: quotient = s1^s2; remainder = s1; product = s1^s2, or s1 only for MULHSU.
//  Multiply: 2*DW product reg. MUL/MULW return low half; MULH/MULHSU/MULHU return high half.
//  Divide: restoring, DW+1-bit partial remainder. DIV*/REM* return quotient / remainder.
//  W results: low DW/2 bits sign-extended to DW (including DIVUW/REMUW).
//  Special cases, no iteration:
//   divisor==0 -> quotient = all ones; remainder = dividend.
//   signed overflow (most-negative / -1, at the W or full width) -> quotient = dividend; remainder = 0.
//  flush: state -> IDLE at the next edge, out_valid low from the next cycle, result dropped; in_ready low during the flush cycle.
//   flush & out_valid & out_ready in the same cycle: the handshake counts as consumed; state -> IDLE.
//  out_valid never drops without out_ready, except on flush or rst.
// STRUCTURE
//  alu_pkg (shared with ALU): M op encodings (MUL..REMU), DW default, FSM state enum {IDLE,CALC,DONE}.
//  Sub-module mdu_sign_fix: combinational abs-value of inputs and conditional negate of the output, reused at entry and exit.
//  The FSM, counter, product/remainder shift registers and the handshake logic stay in mdu_seq.
// TESTING
//  MUL 3*5, out_ready=1 -> out_result=15; out_valid high exactly in cycle T+65, one cycle wide; busy high T+1..T+65.
//  DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 7/0 -> 7; DIVU 7/0 -> all ones, at T+1.
//  DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at T+1. MULW 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE at T+33.
//  MULHU all-ones*all-ones -> 0xFFFF_FFFF_FFFF_FFFE. MULHSU -1*2 -> all ones. MULH -1*-1 -> 0.
//  out_ready held low 10 cycles in DONE -> out_valid and out_result stable; in_ready=0 throughout; accept the next cycle after handshake.
//  flush at cycle T+20 of a DIV -> IDLE, out_valid never rises. rst pulse mid-CALC -> all outputs at reset values immediately.
//  Then a new op completes correctly in both cases.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: M-extension op encodings, default width and sequencer state shared with the ALU.
package alu_pkg;
  localparam int DW_DEF = 64;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
  function automatic logic s1_signed(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic s2_signed(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction
  // MULW/DIVW/REMW sign-extend their W operands; DIVUW/REMUW zero-extend
  function automatic logic w_ext_signed(input logic [2:0] op);
    return ~op[0];
  endfunction
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate, used for operand magnitudes and result sign.
module mdu_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? ~val + W'(1) : val;
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M sequencer, shift-add multiply and restoring divide at one bit per cycle.
module mdu_seq
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic          in_word,
  input  logic [DW-1:0] in_src1,
  input  logic [DW-1:0] in_src2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          busy
);
  localparam int HW = DW / 2;
  localparam int CW = $clog2(DW) + 1;
  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d, neg_q, neg_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [DW:0]     rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d, dvs_q, dvs_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_result_q, out_result_d;
  function automatic logic [DW-1:0] wext(input logic [DW-1:0] v, input logic s);
    return {{HW{s & v[HW-1]}}, v[HW-1:0]};
  endfunction
  logic            accept, s1s, s2s, sa, sb, is_div, is_rem, div_zero, ovf;
  logic [DW-1:0]   a, b, abs_a, abs_b, spec_raw, spec_res;
  assign accept   = in_valid & in_ready;
  assign s1s      = s1_signed(in_op);
  assign s2s      = s2_signed(in_op);
  assign a        = in_word ? wext(in_src1, w_ext_signed(in_op)) : in_src1;
  assign b        = in_word ? wext(in_src2, w_ext_signed(in_op)) : in_src2;
  assign sa       = s1s & a[DW-1];
  assign sb       = s2s & b[DW-1];
  assign is_div   = in_op[2];
  assign is_rem   = in_op[2] & in_op[1];
  assign div_zero = is_div & ~|b;
  assign ovf      = is_div & s1s & (in_word ?
                    (a[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) & (&b[HW-1:0]) :
                    (a == {1'b1, {(DW-1){1'b0}}}) & (&b));
  assign spec_raw = div_zero ? (is_rem ? a : '1) : (is_rem ? '0 : a);
  assign spec_res = in_word ? wext(spec_raw, 1'b1) : spec_raw;
  mdu_sign_fix #(.W(DW)) u_abs_a (.val(a), .neg(sa), .res(abs_a));
  mdu_sign_fix #(.W(DW)) u_abs_b (.val(b), .neg(sb), .res(abs_b));
  // dvs_q holds the multiplicand for multiplies and the divisor for divides
  logic [DW:0]     sum, sh, rem_n;
  logic [DW+1:0]   diff;
  logic [2*DW-1:0] prod_n, fix_in, fixed;
  logic [DW-1:0]   quo_n, lo, fin;
  logic            is_mul_q;
  assign sum    = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, dvs_q} : '0);
  assign prod_n = {sum, prod_q[DW-1:1]};
  assign sh     = {rem_q[DW-1:0], quo_q[DW-1]};
  assign diff   = {1'b0, sh} - {2'b00, dvs_q};
  assign rem_n  = diff[DW+1] ? sh : diff[DW:0];
  assign quo_n  = {quo_q[DW-2:0], ~diff[DW+1]};
  assign is_mul_q = ~op_q[2];
  assign fix_in = is_mul_q ? prod_n : {{DW{1'b0}}, op_q[1] ? rem_n[DW-1:0] : quo_n};
  mdu_sign_fix #(.W(2 * DW)) u_fix (.val(fix_in), .neg(neg_q), .res(fixed));
  // after HW multiply steps the low product half sits at [DW-1:HW]
  assign lo  = ~is_mul_q ? fixed[DW-1:0] :
               (|op_q[1:0]) ? fixed[2*DW-1:DW] :
               word_q ? {{HW{1'b0}}, fixed[DW-1:HW]} : fixed[DW-1:0];
  assign fin = word_q ? wext(lo, 1'b1) : lo;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    word_d       = word_q;
    neg_d        = neg_q;
    prod_d       = prod_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d   = in_op;
        word_d = in_word;
        neg_d  = is_rem ? sa : sa ^ sb;
        if (div_zero | ovf) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_result_d = spec_res;
        end else begin
          state_d = CALC;
          cnt_d   = in_word ? CW'(HW) : CW'(DW);
          prod_d  = {{DW{1'b0}}, abs_a};
          rem_d   = '0;
          quo_d   = in_word ? {abs_a[HW-1:0], {HW{1'b0}}} : abs_a;
          dvs_d   = abs_b;
        end
      end
      CALC: begin
        cnt_d  = cnt_q - CW'(1);
        prod_d = prod_n;
        rem_d  = rem_n;
        quo_d  = quo_n;
        if (cnt_q == CW'(1)) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_result_d = fin;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      word_q       <= 1'b0;
      neg_q        <= 1'b0;
      prod_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      word_q       <= word_d;
      neg_q        <= neg_d;
      prod_q       <= prod_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end
  assign in_ready   = (state_q == IDLE) & ~flush;
  assign busy       = state_q != IDLE;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
endmodule
